uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001: Parameter SIZE_DATA, default 8, width of one transmitted character.
- REQ-002: Parameter NUM_REQ, default 4, number of requesters (legal range 2..8).
- REQ-003: Parameter TIMEOUT, default 200000, maximum clock cycles spent waiting for transmitter completion.
- REQ-004: Port i_clk  input  1  system clock; all state updates on its rising edge.
- REQ-005: Port i_rst  input  1  reset, asynchronous, active-high.
- REQ-006: Port i_req  input  NUM_REQ  per-requester level request, held until acknowledged.
- REQ-007: Port i_data  input  NUM_REQ*SIZE_DATA  requester k's byte in bits [k*SIZE_DATA +: SIZE_DATA].
- REQ-008: Port o_ack  output  NUM_REQ  one-cycle pulse: requester k's byte has been captured.
- REQ-009: Port o_tx_en  output  1  enable to the transmitter.
- REQ-010: Port o_fifo_empty  output  1  "no data" indication to the transmitter; low means o_tx_data is valid.
- REQ-011: Port o_tx_data  output  SIZE_DATA  registered byte presented to the transmitter.
- REQ-012: Port i_tx_done  input  1  one-cycle pulse from the transmitter at end of frame.
- REQ-013: Port o_grant_id  output  clog2(NUM_REQ)  index of the current/last granted requester.
- REQ-014: Port o_busy  output  1  high in every state except IDLE.
- REQ-015: Port o_timeout  output  1  one-cycle pulse when the TIMEOUT watchdog fires.

Function
- REQ-016: The FSM SHALL have states IDLE, SEND, GAP; all outputs SHALL be registered.
- REQ-017: In IDLE with i_req != 0, the arbiter SHALL choose the first set bit searching from priority pointer P upward modulo NUM_REQ.
- REQ-018: On that edge it SHALL load o_tx_data from the winner's slice, set o_grant_id, pulse o_ack[winner], drive o_fifo_empty=0 and o_tx_en=1, and enter SEND (ack and data visible the cycle after the request is sampled).
- REQ-019: P SHALL become (winner+1) mod NUM_REQ on each grant; P is unchanged when no grant occurs.
- REQ-020: o_ack SHALL be one-hot or zero, high for exactly one cycle per grant.
- REQ-021: In SEND, o_tx_data SHALL hold stable, o_tx_en=1 and o_fifo_empty=0 until i_tx_done is sampled high.
- REQ-022: On i_tx_done in SEND: o_fifo_empty=1, o_tx_en=0, enter GAP.
- REQ-023: GAP SHALL last exactly one cycle, then return to IDLE; requests are not evaluated in SEND or GAP.
- REQ-024: A 32-bit watchdog counter SHALL clear on entering SEND and increment each SEND cycle; at TIMEOUT-1 without i_tx_done, pulse o_timeout, drive o_fifo_empty=1, o_tx_en=0, enter GAP.
- REQ-025: i_tx_done in IDLE or GAP SHALL be ignored.
- REQ-026: i_tx_done coinciding with the watchdog terminal cycle SHALL count as completion; no o_timeout pulse.
- REQ-027: A requester dropping i_req before o_ack SHALL not be granted if its bit is low in the sampled cycle.
- REQ-028: Minimum spacing between consecutive o_ack pulses SHALL be 3 cycles (grant, done, GAP).

Reset
- REQ-029: While i_rst is high: state IDLE, P=0, o_ack=0, o_tx_en=0, o_fifo_empty=1, o_tx_data=0, o_grant_id=0, o_busy=0, o_timeout=0, watchdog=0.
- REQ-030: Reset asserted mid-SEND SHALL abort the frame immediately; no o_ack or o_timeout after deassertion until a new request is sampled.
- REQ-031: The first grant after reset SHALL favour requester 0.

Verification
- REQ-032: Single request: i_req=4'b0100, i_data[2]=8'h55 -> o_ack=4'b0100 one cycle, o_tx_data=8'h55, o_fifo_empty=0; done pulse -> o_fifo_empty=1, GAP, IDLE.
- REQ-033: Round-robin: i_req=4'b1111 held, each acked requester re-requests -> grant order 0,1,2,3,0.
- REQ-034: Pointer wrap: after grant to 3, i_req=4'b1001 -> grant 0, then 3.
- REQ-035: Timeout: TIMEOUT=16, grant with no i_tx_done -> o_timeout pulse exactly 16 cycles after SEND entry, o_fifo_empty=1.
- REQ-036: Reset mid-SEND (i_rst high 2 cycles) -> all outputs at REQ-029 values, next grant favours requester 0.
- REQ-037: Full chain with baud_generator (BAUDRATE_VALUE 325, 50 MHz) and Transmitter: bytes 8'h55 then 8'hA3 from requesters 1 and 2 -> both serialized in grant order, o_timeout never asserted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one character at a time from NUM_REQ requesters
// to a UART transmitter, with a watchdog on transmitter completion.
module uart_tx_arbiter #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 200000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_data,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic                           o_tx_en,
  output logic                           o_fifo_empty,
  output logic [SIZE_DATA-1:0]           o_tx_data,
  input  logic                           i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int              ID_W    = $clog2(NUM_REQ);
  localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [31:0]     WD_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [31:0]     wdog;

  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] next_ptr;
  logic            found;
  logic [ID_W:0]   raw;
  logic [ID_W:0]   idx;
  logic            hit;

  // First requesting index at or above the priority pointer, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    raw    = '0;
    idx    = '0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      raw    = {1'b0, ptr} + (ID_W+1)'(i);
      idx    = (raw >= NREQ) ? (raw - NREQ) : raw;
      hit    = !found && i_req[idx[ID_W-1:0]];
      winner = hit ? idx[ID_W-1:0] : winner;
      found  = found | hit;
    end
    next_ptr = (winner == LAST_ID) ? '0 : (winner + ID_W'(1));
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      ptr          <= '0;
      wdog         <= 32'd0;
      o_ack        <= '0;
      o_tx_en      <= 1'b0;
      o_fifo_empty <= 1'b1;
      o_tx_data    <= '0;
      o_grant_id   <= '0;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_ack     <= '0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state        <= SEND;
            ptr          <= next_ptr;
            wdog         <= 32'd0;
            o_ack        <= NUM_REQ'(1) << winner;
            o_grant_id   <= winner;
            o_tx_data    <= i_data[winner*SIZE_DATA +: SIZE_DATA];
            o_fifo_empty <= 1'b0;
            o_tx_en      <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        SEND: begin
          // A done pulse on the terminal watchdog cycle still counts as completion.
          if (i_tx_done) begin
            o_fifo_empty <= 1'b1;
            o_tx_en      <= 1'b0;
            state        <= GAP;
          end else if (wdog == WD_LAST) begin
            o_timeout    <= 1'b1;
            o_fifo_empty <= 1'b1;
            o_tx_en      <= 1'b0;
            state        <= GAP;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        GAP: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          o_tx_en      <= 1'b0;
          o_fifo_empty <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        tx_en;
  logic        fifo_empty;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;

  int total;
  int bad;

  logic [7:0] exp_byte [4];

  uart_tx_arbiter #(.SIZE_DATA(8), .NUM_REQ(4), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_ack(ack), .o_tx_en(tx_en), .o_fifo_empty(fifo_empty),
    .o_tx_data(tx_data), .i_tx_done(tx_done), .o_grant_id(grant_id),
    .o_busy(busy), .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; tx_done = 1'b0;
    data = 32'hA355C60F;
    tick(); tick();
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en got=%b want=0", tx_en); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_fifo_empty got=%b want=1", fifo_empty); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL reset_busy_timeout got=%b%b want=00", busy, timeout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b want=0100", ack); end
    total++; if (tx_data !== 8'h55) begin bad++; $display("FAIL single_data got=%h want=55", tx_data); end
    total++; if (fifo_empty !== 1'b0 || tx_en !== 1'b1) begin bad++; $display("FAIL single_send_flags got=%b%b want=01", fifo_empty, tx_en); end
    total++; if (grant_id !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL single_grant got=%0d/%b want=2/1", grant_id, busy); end
    tick(); tick(); tick();
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_ack_pulse got=%b want=0000", ack); end
    total++; if (tx_data !== 8'h55 || tx_en !== 1'b1 || fifo_empty !== 1'b0) begin bad++; $display("FAIL single_hold got=%h/%b/%b want=55/1/0", tx_data, tx_en, fifo_empty); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++; if (fifo_empty !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_gap got=%b/%b/%b want=1/0/1", fifo_empty, tx_en, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_idle_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || fifo_empty !== 1'b1 || ack !== 4'b0000) begin bad++; $display("FAIL idle_done got=%b/%b/%b want=0/1/0000", busy, fifo_empty, ack); end
    // pointer is still 3 after the grant to requester 2
    req = 4'b1001;
    tick();
    req = 4'b0000;
    total++; if (ack !== 4'b1000 || grant_id !== 2'd3) begin bad++; $display("FAIL idle_ptr_kept got=%b/%0d want=1000/3", ack, grant_id); end
    total++; if (tx_data !== exp_byte[3]) begin bad++; $display("FAIL idle_ptr_data got=%h want=%h", tx_data, exp_byte[3]); end
    finish_frame();
  endtask

  task automatic test_round_robin();
    int cnt;
    int exp_id;
    logic [3:0] exp_ack;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      exp_ack = 4'b0001 << exp_id;
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (ack === 4'b0000 && cnt < 8);
      total++; if (ack !== exp_ack || grant_id !== exp_id[1:0]) begin bad++; $display("FAIL rr_grant%0d got=%b/%0d want=%b/%0d", k, ack, grant_id, exp_ack, exp_id); end
      total++; if (tx_data !== exp_byte[exp_id]) begin bad++; $display("FAIL rr_data%0d got=%h want=%h", k, tx_data, exp_byte[exp_id]); end
      if (k > 0) begin
        total++; if (cnt !== 2) begin bad++; $display("FAIL rr_spacing%0d got=%0d want=2", k, cnt); end
      end
      if (k == 4) req = 4'b0000;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    tick();
  endtask

  task automatic test_wrap();
    req = 4'b1000;
    tick();
    total++; if (ack !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b want=1000", ack); end
    req = 4'b1001;
    finish_frame();
    tick();
    total++; if (ack !== 4'b0001 || grant_id !== 2'd0) begin bad++; $display("FAIL wrap_to0 got=%b/%0d want=0001/0", ack, grant_id); end
    finish_frame();
    tick();
    req = 4'b0000;
    total++; if (ack !== 4'b1000 || grant_id !== 2'd3) begin bad++; $display("FAIL wrap_to3 got=%b/%0d want=1000/3", ack, grant_id); end
    finish_frame();
  endtask

  task automatic test_timeout();
    int cnt;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL to_grant got=%b want=0001", ack); end
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (timeout !== 1'b1 && cnt < 40);
    total++; if (cnt !== 16) begin bad++; $display("FAIL to_latency got=%0d want=16", cnt); end
    total++; if (fifo_empty !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_flags got=%b/%b/%b want=1/0/1", fifo_empty, tx_en, busy); end
    tick();
    total++; if (timeout !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b/%b want=0/0", timeout, busy); end
  endtask

  task automatic test_done_terminal();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL term_grant got=%b want=0010", ack); end
    repeat (15) tick();
    total++; if (timeout !== 1'b0 || tx_en !== 1'b1) begin bad++; $display("FAIL term_early got=%b/%b want=0/1", timeout, tx_en); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++; if (timeout !== 1'b0 || fifo_empty !== 1'b1 || tx_en !== 1'b0) begin bad++; $display("FAIL term_done got=%b/%b/%b want=0/1/0", timeout, fifo_empty, tx_en); end
    tick();
    total++; if (timeout !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL term_after got=%b/%b want=0/0", timeout, busy); end
  endtask

  task automatic test_reset_mid_send();
    logic seen;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick(); tick();
    rst = 1'b1;
    #1;
    total++; if (ack !== 4'b0000 || tx_en !== 1'b0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_flags got=%b/%b/%b want=0000/0/1", ack, tx_en, fifo_empty); end
    total++; if (tx_data !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL mid_rst_regs got=%h/%0d/%b/%b want=00/0/0/0", tx_data, grant_id, busy, timeout); end
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (ack !== 4'b0000 || timeout !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet got=%b want=0", seen); end
    req = 4'b1001;
    tick();
    req = 4'b0000;
    total++; if (ack !== 4'b0001 || grant_id !== 2'd0) begin bad++; $display("FAIL mid_rst_favour0 got=%b/%0d want=0001/0", ack, grant_id); end
    finish_frame();
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_byte[0] = 8'h0F;
    exp_byte[1] = 8'hC6;
    exp_byte[2] = 8'h55;
    exp_byte[3] = 8'hA3;
    test_reset();
    test_single();
    test_idle_done();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_done_terminal();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
